// File: rtl/s100_pkg.sv
// Shared state encoding and default timing for the S100 I/O cycle engine.
package s100_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_STROBE,
    ST_WAITRDY,
    ST_DONE
  } state_e;

  localparam int DEF_SYNC_CYCLES    = 2;
  localparam int DEF_STROBE_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // A phase of n clocks ends on the edge that finds the timer at zero.
  function automatic logic [7:0] phase_load(input int n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/s100_io_cycle_if.sv
// Z80-side strobes and S100-side bus for the I/O cycle engine.
interface s100_io_cycle_if;
  logic       cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
  logic [7:0] cpu_addr, cpu_dout;
  logic       int_port;
  logic       s100_rdy;
  logic [7:0] s100_din;
  logic       cpu_wait_n;
  logic       s_inp, s_out, p_sync, p_dbin, p_wr_n;
  logic [7:0] s100_addr, s100_dout, s100DataIn;
  logic       inPortcon_cs;
  logic       io_timeout;

  modport master (
    output cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_addr, cpu_dout,
           int_port, s100_rdy, s100_din,
    input  cpu_wait_n, s_inp, s_out, p_sync, p_dbin, p_wr_n,
           s100_addr, s100_dout, s100DataIn, inPortcon_cs, io_timeout
  );

  modport slave (
    input  cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_addr, cpu_dout,
           int_port, s100_rdy, s100_din,
    output cpu_wait_n, s_inp, s_out, p_sync, p_dbin, p_wr_n,
           s100_addr, s100_dout, s100DataIn, inPortcon_cs, io_timeout
  );
endinterface

// File: rtl/s100_cycle_timer.sv
// Loadable 8-bit down-counter; saturates at zero and flags it.
module s100_cycle_timer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = load_val;
    else if (dec && cnt_q != '0)  cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 8'd0);
endmodule

// File: rtl/s100_io_cycle.sv
// Bridges Z80 I/O cycles onto the S100 bus: status, pSYNC, strobes, RDY wait
// with timeout, and read-data capture for the CPU data-in mux.
module s100_io_cycle import s100_pkg::*; #(
  parameter int SYNC_CYCLES    = DEF_SYNC_CYCLES,
  parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic          clock,
  input  logic          reset_n,
  s100_io_cycle_if.slave bus
);
  localparam logic [7:0] SYNC_LD    = phase_load(SYNC_CYCLES);
  localparam logic [7:0] STROBE_LD  = phase_load(STROBE_CYCLES);
  localparam logic [7:0] TIMEOUT_LD = phase_load(TIMEOUT_CYCLES);

  state_e     state_q, state_d;
  logic       rd_q, rd_d;
  logic       armed_q, armed_d;
  logic [7:0] addr_q, addr_d, dout_q, dout_d, din_q, din_d;
  logic       tmo_q, tmo_d;
  logic       wait_n_q, wait_n_d, s_inp_q, s_inp_d, s_out_q, s_out_d;
  logic       p_sync_q, p_sync_d, p_dbin_q, p_dbin_d, p_wr_n_q, p_wr_n_d;
  logic       cs_q, cs_d;
  logic       tmr_load, tmr_dec, tmr_zero;
  logic [7:0] tmr_val;
  logic       start, busy_d, strobe_d;

  s100_cycle_timer u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // armed_q blocks a start until IORQ has been seen high after reset.
  assign start = armed_q && !bus.cpu_iorq_n && bus.cpu_m1_n && !bus.int_port &&
                 (bus.cpu_rd_n ^ bus.cpu_wr_n);

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    din_d    = din_q;
    tmo_d    = tmo_q;
    armed_d  = armed_q | bus.cpu_iorq_n;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_SYNC;
        rd_d     = !bus.cpu_rd_n;
        addr_d   = bus.cpu_addr;
        if (bus.cpu_rd_n) dout_d = bus.cpu_dout;
        tmr_load = 1'b1;
        tmr_val  = SYNC_LD;
      end
      ST_SYNC: begin
        if (bus.cpu_iorq_n) state_d = ST_IDLE;
        else if (tmr_zero) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end else tmr_dec = 1'b1;
      end
      // RDY is first sampled on the edge that ends the minimum strobe width,
      // so an already-ready bus sees exactly STROBE_CYCLES of strobe.
      ST_STROBE: begin
        if (bus.cpu_iorq_n) state_d = ST_IDLE;
        else if (tmr_zero) begin
          if (bus.s100_rdy) begin
            state_d = ST_DONE;
            if (rd_q) din_d = bus.s100_din;
          end else begin
            state_d  = ST_WAITRDY;
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_LD;
          end
        end else tmr_dec = 1'b1;
      end
      ST_WAITRDY: begin
        if (bus.cpu_iorq_n) state_d = ST_IDLE;
        else if (bus.s100_rdy) begin
          state_d = ST_DONE;
          if (rd_q) din_d = bus.s100_din;
        end else if (tmr_zero) begin
          state_d = ST_DONE;
          din_d   = 8'hFF;
          tmo_d   = 1'b1;
        end else tmr_dec = 1'b1;
      end
      ST_DONE: if (bus.cpu_iorq_n) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d   = state_d inside {ST_SYNC, ST_STROBE, ST_WAITRDY};
    strobe_d = state_d inside {ST_STROBE, ST_WAITRDY};
    wait_n_d = !busy_d;
    s_inp_d  = (state_d != ST_IDLE) && rd_d;
    s_out_d  = (state_d != ST_IDLE) && !rd_d;
    p_sync_d = (state_d == ST_SYNC);
    p_dbin_d = strobe_d && rd_d;
    p_wr_n_d = !(strobe_d && !rd_d);
    cs_d     = (state_d == ST_DONE) && rd_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rd_q     <= 1'b0;
      armed_q  <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      din_q    <= '0;
      tmo_q    <= 1'b0;
      wait_n_q <= 1'b1;
      s_inp_q  <= 1'b0;
      s_out_q  <= 1'b0;
      p_sync_q <= 1'b0;
      p_dbin_q <= 1'b0;
      p_wr_n_q <= 1'b1;
      cs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      armed_q  <= armed_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      din_q    <= din_d;
      tmo_q    <= tmo_d;
      wait_n_q <= wait_n_d;
      s_inp_q  <= s_inp_d;
      s_out_q  <= s_out_d;
      p_sync_q <= p_sync_d;
      p_dbin_q <= p_dbin_d;
      p_wr_n_q <= p_wr_n_d;
      cs_q     <= cs_d;
    end
  end

  assign bus.cpu_wait_n   = wait_n_q;
  assign bus.s_inp        = s_inp_q;
  assign bus.s_out        = s_out_q;
  assign bus.p_sync       = p_sync_q;
  assign bus.p_dbin       = p_dbin_q;
  assign bus.p_wr_n       = p_wr_n_q;
  assign bus.s100_addr    = addr_q;
  assign bus.s100_dout    = dout_q;
  assign bus.s100DataIn   = din_q;
  assign bus.inPortcon_cs = cs_q;
  assign bus.io_timeout   = tmo_q;
endmodule

// File: doc/s100_io_cycle.md
S100_IO_CYCLE -- requirements
Module: s100_io_cycle

Interface
REQ-001 Parameter SYNC_CYCLES, default 2, clocks pSYNC is held high at cycle start (1..15).
REQ-002 Parameter STROBE_CYCLES, default 4, minimum clocks pDBIN/pWR_n stay asserted before RDY is sampled (1..15).
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum clocks spent waiting for bus RDY (1..255).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  system clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n  in  1 each  Z80 control strobes, already synchronised to clock.
REQ-008 cpu_addr  in  8  Z80 A7..A0 port number.
REQ-009 cpu_dout  in  8  Z80 write data.
REQ-010 int_port  in  1  high when the port is served inside the FPGA; such cycles are ignored.
REQ-011 s100_rdy  in  1  S100 bus ready, active high.
REQ-012 s100_din  in  8  S100 data-in bus.
REQ-013 cpu_wait_n  out  1  Z80 WAIT, low stretches the cycle.
REQ-014 s_inp, s_out, p_sync, p_dbin, p_wr_n  out  1 each  S100 status and strobes.
REQ-015 s100_addr  out  8  latched port address; s100_dout  out  8  latched write data.
REQ-016 s100DataIn  out  8  latched read data for the CPU data-in mux.
REQ-017 inPortcon_cs  out  1  high while s100DataIn is valid for the CPU.
REQ-018 io_timeout  out  1  sticky flag, set on any RDY timeout.

Function
REQ-019 A cycle starts in IDLE when cpu_iorq_n=0, cpu_m1_n=1, int_port=0, and exactly one of cpu_rd_n/cpu_wr_n is 0; address and write data are latched on that edge.
REQ-020 IORQ with cpu_m1_n=0 (interrupt acknowledge), or with both rd/wr low, shall not start a cycle.
REQ-021 States: IDLE -> SYNC -> STROBE -> WAITRDY -> DONE -> IDLE.
REQ-022 SYNC: p_sync=1 for SYNC_CYCLES clocks; s_inp (read) or s_out (write) asserted from SYNC through DONE.
REQ-023 STROBE: p_dbin=1 (read) or p_wr_n=0 (write) for STROBE_CYCLES clocks; strobe remains asserted through WAITRDY.
REQ-024 WAITRDY: on the first clock with s100_rdy=1, read cycles capture s100_din into s100DataIn and go to DONE.
REQ-025 WAITRDY lasting TIMEOUT_CYCLES clocks without RDY: s100DataIn = 8'hFF, io_timeout=1, go to DONE.
REQ-026 cpu_wait_n = 0 from the clock after the start edge until the DONE entry edge; 1 in IDLE and DONE.
REQ-027 DONE: strobes deasserted; inPortcon_cs=1 (read cycles only) until cpu_iorq_n returns high, then IDLE on the next edge.
REQ-028 Back-to-back cycles: a new cycle starts no earlier than one IDLE clock after cpu_iorq_n=1.
REQ-029 cpu_iorq_n rising before DONE (aborted cycle): drop all strobes and status next clock, return to IDLE; s100DataIn unchanged; inPortcon_cs stays 0.
REQ-030 Cycle counters are 8 bits; each clears on every state entry and never wraps.
REQ-031 io_timeout clears only on reset.

Reset
REQ-032 Reset asserted at any time forces IDLE immediately: cpu_wait_n=1, p_wr_n=1, s_inp=s_out=p_sync=p_dbin=0, inPortcon_cs=0, io_timeout=0, s100DataIn=8'h00, s100_addr=8'h00, s100_dout=8'h00, counters 0.
REQ-033 Reset deassertion mid-CPU-cycle shall not start a cycle until cpu_iorq_n has been seen high.

Structure
REQ-034 State encoding and the default cycle constants shall live in shared package s100_pkg.
REQ-035 One sub-module, s100_cycle_timer (loadable 8-bit down-counter with a zero flag), serves SYNC, STROBE and timeout counts.

Verification
REQ-036 IN from port 0x01, RDY at 3 clocks into WAITRDY, din=0xA5 -> p_sync 2 clocks, p_dbin ≥4 clocks, s100DataIn=0xA5, inPortcon_cs=1 until IORQ high, cpu_wait_n released.
REQ-037 OUT to port 0x10, data 0x3C, RDY immediately -> s_out=1, s100_addr=0x10, s100_dout=0x3C, p_wr_n low exactly 4 clocks, inPortcon_cs stays 0.
REQ-038 IN, RDY never asserted -> after 255 WAITRDY clocks, s100DataIn=0xFF, io_timeout=1, cpu_wait_n=1.
REQ-039 IORQ with M1=0, or int_port=1 -> no S100 strobes, cpu_wait_n stays 1.
REQ-040 reset_n pulsed low during STROBE -> all outputs at reset values on the same edge; no cycle until IORQ seen high.
REQ-041 IORQ withdrawn during WAITRDY -> strobes drop next clock, IDLE, s100DataIn keeps its previous value.
